// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the LC-3 MAR/MDR bus.
// Serves on-chip word memory plus one memory-mapped I/O address
// (reads return Switches, writes load HEX_Data) after WAIT_STATES cycles.
// Optional macro MEM_ADDR_CHECK_EN: flag and suppress accesses whose address
// has bits set above the memory index (IO_ADDR excepted); otherwise such
// addresses alias into the memory and Addr_err stays 0.
module mem_io_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] Switches,
    output logic [15:0] MDR_In,
    output logic        R,
    output logic        Busy,
    output logic [15:0] HEX_Data,
    output logic        Addr_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [15:0]         r_addr;
    logic [15:0]         r_wdata;
    logic                r_we;
    logic                r_r;
    logic                r_busy;
    logic [15:0]         r_mdr_in;
    logic [15:0]         r_hex;
    logic [15:0]         r_mem [0:(1<<ADDR_W)-1];

    logic [15:0]         w_addr;
    logic [15:0]         w_wdata;
    logic                w_we;
    logic                w_xfer;
    logic                w_is_io;
    logic                w_oor;
    logic [ADDR_W-1:0]   w_idx;
    logic [15:0]         w_rdata;

    // Next-state logic for the request handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (MEM_REQ) w_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            S_WAIT:    if (r_cnt == 4'd0) w_next = S_ACK;
            S_ACK:     w_next = S_RELEASE;
            S_RELEASE: if (!MEM_REQ) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // With zero wait states the transfer happens on the accept edge itself,
    // so the request must come straight off the bus instead of the latches.
    assign w_addr  = (r_state == S_IDLE) ? MAR    : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? MDR    : r_wdata;
    assign w_we    = (r_state == S_IDLE) ? MEM_WE : r_we;
    assign w_xfer  = (w_next == S_ACK);
    assign w_is_io = (w_addr == IO_ADDR);
    assign w_idx   = w_addr[ADDR_W-1:0];
    assign w_rdata = r_mem[w_idx];

`ifdef MEM_ADDR_CHECK_EN
    logic r_addr_err;
    assign w_oor    = !w_is_io && ((w_addr >> ADDR_W) != 16'h0000);
    assign Addr_err = r_addr_err;

    // Sticky out-of-range flag, cleared only by reset
    always_ff @(posedge Clk) begin
        if (Reset_ah)
            r_addr_err <= 1'b0;
        else if (w_xfer && w_oor)
            r_addr_err <= 1'b1;
    end
`else
    assign w_oor    = 1'b0;
    assign Addr_err = 1'b0;
`endif

    // Memory array: never reset; a reset edge blocks the pending write
    always_ff @(posedge Clk) begin
        if (!Reset_ah && w_xfer && w_we && !w_is_io && !w_oor)
            r_mem[w_idx] <= w_wdata;
    end

    // FSM state, request latches, wait counter and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 16'h0000;
            r_wdata  <= 16'h0000;
            r_we     <= 1'b0;
            r_r      <= 1'b0;
            r_busy   <= 1'b0;
            r_mdr_in <= 16'h0000;
            r_hex    <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_r     <= w_xfer;
            r_busy  <= (w_next != S_IDLE);
            if (r_state == S_IDLE && MEM_REQ) begin
                r_addr  <= MAR;
                r_wdata <= MDR;
                r_we    <= MEM_WE;
                r_cnt   <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_xfer) begin
                if (!w_we)
                    r_mdr_in <= w_is_io ? Switches : (w_oor ? 16'h0000 : w_rdata);
                else if (w_is_io)
                    r_hex <= w_wdata;
            end
        end
    end

    assign MDR_In   = r_mdr_in;
    assign R        = r_r;
    assign Busy     = r_busy;
    assign HEX_Data = r_hex;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (default parameters).
module tb_mem_io_responder;

    logic        Clk = 1'b0;
    logic        Reset_ah = 1'b1;
    logic [15:0] MAR = 16'h0000;
    logic [15:0] MDR = 16'h0000;
    logic        MEM_REQ = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [15:0] Switches = 16'h0000;
    logic [15:0] MDR_In;
    logic        R;
    logic        Busy;
    logic [15:0] HEX_Data;
    logic        Addr_err;

    int checks = 0;
    int failures = 0;

    mem_io_responder dut (
        .Clk(Clk), .Reset_ah(Reset_ah), .MAR(MAR), .MDR(MDR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .Switches(Switches),
        .MDR_In(MDR_In), .R(R), .Busy(Busy), .HEX_Data(HEX_Data),
        .Addr_err(Addr_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: normal; 1: drop MEM_REQ during WAIT; 2: scramble bus during WAIT.
    // lat counts falling edges from the accept edge until R is seen high.
    task automatic xact(input logic [15:0] a, input logic [15:0] d, input logic we,
                        input int hold, input int mode,
                        output int lat, output int rcnt, output logic busy_hold);
        @(negedge Clk);
        MAR = a; MDR = d; MEM_WE = we; MEM_REQ = 1'b1;
        @(posedge Clk);
        rcnt = 0;
        @(negedge Clk);
        lat = 1;
        if (mode == 1) MEM_REQ = 1'b0;
        if (mode == 2) begin MAR = a + 16'd1; MDR = ~d; MEM_WE = ~we; end
        while (!R && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        if (R) rcnt = 1;
        repeat (hold + 1) begin
            @(negedge Clk);
            if (R) rcnt++;
        end
        busy_hold = Busy;
        MEM_REQ = 1'b0;
        @(negedge Clk);
    endtask

    int   lat, rc;
    logic bh;

    initial begin
        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_ah = 1'b0;
        chk("rst_R", {15'h0, R}, 16'h0);
        chk("rst_busy", {15'h0, Busy}, 16'h0);
        chk("rst_mdr_in", MDR_In, 16'h0000);
        chk("rst_hex", HEX_Data, 16'h0000);
        chk("rst_addr_err", {15'h0, Addr_err}, 16'h0);

        // Write then read of 0x0005
        xact(16'h0005, 16'h1234, 1'b1, 0, 0, lat, rc, bh);
        chk("wr5_latency", 16'(lat), 16'd3);
        chk("wr5_rcount", 16'(rc), 16'd1);
        chk("wr5_mdr_in_unchanged", MDR_In, 16'h0000);
        chk("wr5_busy_after", {15'h0, Busy}, 16'h0);
        xact(16'h0005, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("rd5_latency", 16'(lat), 16'd3);
        chk("rd5_data", MDR_In, 16'h1234);

        // IO read returns switches, memory untouched
        Switches = 16'hBEEF;
        xact(16'hFFFF, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("io_rd_data", MDR_In, 16'hBEEF);
        xact(16'h0005, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("io_rd_mem_kept", MDR_In, 16'h1234);

        // IO write loads HEX, does not alias into mem[0x3FF]
        xact(16'h03FF, 16'h3FF3, 1'b1, 0, 0, lat, rc, bh);
        xact(16'hFFFF, 16'h00A5, 1'b1, 0, 0, lat, rc, bh);
        chk("io_wr_hex", HEX_Data, 16'h00A5);
        xact(16'h03FF, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("io_wr_mem_3ff", MDR_In, 16'h3FF3);

        // Request held 5 cycles past R: one pulse, stays busy, then idles
        xact(16'h0005, 16'h0000, 1'b0, 5, 0, lat, rc, bh);
        chk("hold_rcount", 16'(rc), 16'd1);
        chk("hold_busy", {15'h0, bh}, 16'h1);
        chk("hold_idle_after", {15'h0, Busy}, 16'h0);

        // Bus changes during WAIT are ignored
        xact(16'h0008, 16'h8888, 1'b1, 0, 0, lat, rc, bh);
        xact(16'h0007, 16'h7777, 1'b1, 0, 2, lat, rc, bh);
        chk("scr_latency", 16'(lat), 16'd3);
        xact(16'h0007, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("scr_rd7", MDR_In, 16'h7777);
        xact(16'h0008, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("scr_rd8", MDR_In, 16'h8888);

        // MEM_REQ dropped during WAIT: still completes
        xact(16'h0010, 16'hAAAA, 1'b1, 0, 1, lat, rc, bh);
        chk("drop_latency", 16'(lat), 16'd3);
        chk("drop_rcount", 16'(rc), 16'd1);
        chk("drop_idle", {15'h0, Busy}, 16'h0);

        // Reset during WAIT of a write to 0x0010 aborts it
        @(negedge Clk);
        MAR = 16'h0010; MDR = 16'hDEAD; MEM_WE = 1'b1; MEM_REQ = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset_ah = 1'b1;
        rc = 0;
        @(negedge Clk);
        Reset_ah = 1'b0;
        MEM_REQ = 1'b0;
        chk("rst_mid_mdr_in", MDR_In, 16'h0000);
        chk("rst_mid_hex", HEX_Data, 16'h0000);
        chk("rst_mid_busy", {15'h0, Busy}, 16'h0);
        repeat (6) begin
            @(negedge Clk);
            if (R) rc++;
        end
        chk("rst_mid_no_r", 16'(rc), 16'd0);
        xact(16'h0010, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("rst_mid_mem_kept", MDR_In, 16'hAAAA);

        // Out-of-range write to 0x0405
        xact(16'h0405, 16'h5555, 1'b1, 0, 0, lat, rc, bh);
        chk("oor_latency", 16'(lat), 16'd3);
        xact(16'h0005, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
`ifdef MEM_ADDR_CHECK_EN
        chk("oor_rd5", MDR_In, 16'h1234);
        chk("oor_err", {15'h0, Addr_err}, 16'h1);
        xact(16'h0405, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("oor_rd405", MDR_In, 16'h0000);
`else
        chk("oor_rd5", MDR_In, 16'h5555);
        chk("oor_err", {15'h0, Addr_err}, 16'h0);
        xact(16'h0405, 16'h0000, 1'b0, 0, 0, lat, rc, bh);
        chk("oor_rd405", MDR_In, 16'h5555);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
